// File: rtl/i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_regfile
// Brief    : SMBus-style byte register file behind an I2C slave byte stream,
//            with a local fabric read/write port and an I2C write-notify strobe.
// Revision : 1.0
// ============================================================================
module i2c_slave_regfile #(
    parameter int unsigned                  ADDR_WIDTH = 4,
    parameter logic [(2**ADDR_WIDTH)-1:0]   RO_MASK    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    input  logic                  bus_addressed,
    input  logic                  reg_wr_en,
    input  logic [ADDR_WIDTH-1:0] reg_wr_addr,
    input  logic [7:0]            reg_wr_data,
    input  logic [ADDR_WIDTH-1:0] reg_rd_addr,
    output logic [7:0]            reg_rd_data,
    output logic                  i2c_wr_valid,
    output logic [ADDR_WIDTH-1:0] i2c_wr_addr,
    output logic [7:0]            i2c_wr_data,
    output logic [ADDR_WIDTH-1:0] ptr
);

    localparam int unsigned NUM_REGS = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_PTR  = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [7:0]              regs_q [NUM_REGS];
    logic [7:0]              regs_d [NUM_REGS];
    logic [7:0]              m_tdata_q, m_tdata_d;
    logic                    m_tvalid_q, m_tvalid_d;
    logic [7:0]              rd_data_q;
    logic                    wr_valid_q, wr_valid_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]              wr_data_q, wr_data_d;
    logic                    bus_addressed_q;

    logic w_rx;
    logic w_rd_hs;
    logic w_i2c_we;
    logic w_local_hit;

    assign s_axis_tready = ~rst;
    assign w_rx          = s_axis_tvalid & s_axis_tready;
    assign w_rd_hs       = m_tvalid_q & m_axis_tready;
    assign w_local_hit   = reg_wr_en && (reg_wr_addr == ptr_q);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        w_i2c_we   = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end

        // A received byte owns the pointer; a coincident read increment is lost.
        if (w_rx) begin
            if (state_q == ST_PTR) begin
                ptr_d = s_axis_tdata[ADDR_WIDTH-1:0];
                if (!s_axis_tlast) begin
                    state_d = ST_DATA;
                end
            end else begin
                if (!RO_MASK[ptr_q]) begin
                    w_i2c_we   = 1'b1;
                    wr_valid_d = 1'b1;
                    wr_addr_d  = ptr_q;
                    wr_data_d  = s_axis_tdata;
                end
                ptr_d = ptr_q + C_PTR_ONE;
                if (s_axis_tlast) begin
                    state_d = ST_PTR;
                end
            end
        end else if (w_rd_hs) begin
            ptr_d = ptr_q + C_PTR_ONE;
        end

        if (bus_addressed_q && !bus_addressed) begin
            state_d = ST_PTR;
        end

        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_i2c_we && (ptr_q == ADDR_WIDTH'(i))) begin
                regs_d[i] = s_axis_tdata;
            end else if (reg_wr_en && (reg_wr_addr == ADDR_WIDTH'(i))) begin
                regs_d[i] = reg_wr_data;
            end
        end

        // Any event that could stale the holding register forces one reload bubble.
        if (w_rx || w_rd_hs || w_local_hit) begin
            m_tvalid_d = 1'b0;
        end else if (!m_tvalid_q) begin
            m_tdata_d  = regs_q[ptr_q];
            m_tvalid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_PTR;
            ptr_q           <= '0;
            m_tdata_q       <= '0;
            m_tvalid_q      <= 1'b0;
            rd_data_q       <= '0;
            wr_valid_q      <= 1'b0;
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
            bus_addressed_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            m_tdata_q       <= m_tdata_d;
            m_tvalid_q      <= m_tvalid_d;
            rd_data_q       <= regs_q[reg_rd_addr];
            wr_valid_q      <= wr_valid_d;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
            bus_addressed_q <= bus_addressed;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = 1'b0;
    assign reg_rd_data   = rd_data_q;
    assign i2c_wr_valid  = wr_valid_q;
    assign i2c_wr_addr   = wr_addr_q;
    assign i2c_wr_data   = wr_data_q;
    assign ptr           = ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_regfile
// Brief    : Directed self-checking bench for i2c_slave_regfile.
// Revision : 1.0
// ============================================================================
module tb_i2c_slave_regfile;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_axis_tdata = '0;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic       s_axis_tlast = 1'b0;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b0;
    logic       m_axis_tlast;
    logic       bus_addressed = 1'b0;
    logic       reg_wr_en = 1'b0;
    logic [3:0] reg_wr_addr = '0;
    logic [7:0] reg_wr_data = '0;
    logic [3:0] reg_rd_addr = '0;
    logic [7:0] reg_rd_data;
    logic       i2c_wr_valid;
    logic [3:0] i2c_wr_addr;
    logic [7:0] i2c_wr_data;
    logic [3:0] ptr;

    int vecs = 0;
    int errs = 0;

    i2c_slave_regfile #(
        .ADDR_WIDTH (4),
        .RO_MASK    (16'h0004)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .bus_addressed (bus_addressed),
        .reg_wr_en     (reg_wr_en),
        .reg_wr_addr   (reg_wr_addr),
        .reg_wr_data   (reg_wr_data),
        .reg_rd_addr   (reg_rd_addr),
        .reg_rd_data   (reg_rd_data),
        .i2c_wr_valid  (i2c_wr_valid),
        .i2c_wr_addr   (i2c_wr_addr),
        .i2c_wr_data   (i2c_wr_data),
        .ptr           (ptr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] wa;
        logic [7:0] wd;
        logic [3:0] ra;
        logic [7:0] exp_rd;
    } lvec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic local_read(input logic [3:0] a, input logic [7:0] exp, input string name);
        reg_rd_addr = a;
        tick();
        check(name, {24'd0, reg_rd_data}, {24'd0, exp});
    endtask

    initial begin
        lvec_t lv [6];
        logic [7:0] rd_exp [3];
        lv[0] = '{4'h5, 8'h5A, 4'h3, 8'hAA};
        lv[1] = '{4'h6, 8'h6B, 4'h4, 8'hBB};
        lv[2] = '{4'h7, 8'hC3, 4'h5, 8'h5A};
        lv[3] = '{4'hA, 8'hF0, 4'h6, 8'h6B};
        lv[4] = '{4'hB, 8'h0F, 4'hA, 8'hF0};
        lv[5] = '{4'hC, 8'h81, 4'h7, 8'hC3};
        rd_exp[0] = 8'hBB;
        rd_exp[1] = 8'h5A;
        rd_exp[2] = 8'h6B;

        // Reset state
        tick();
        tick();
        check("rst_tready", {31'd0, s_axis_tready}, 0);
        check("rst_tvalid", {31'd0, m_axis_tvalid}, 0);
        check("rst_ptr", {28'd0, ptr}, 0);
        check("rst_wr_valid", {31'd0, i2c_wr_valid}, 0);
        check("rst_tlast", {31'd0, m_axis_tlast}, 0);
        rst = 1'b0;
        tick();
        check("first_prefetch_valid", {31'd0, m_axis_tvalid}, 1);
        check("first_prefetch_data", {24'd0, m_axis_tdata}, 0);
        check("tready_up", {31'd0, s_axis_tready}, 1);

        // Pointer and data burst
        bus_addressed = 1'b1;
        send(8'h03, 1'b0);
        check("burst_ptr0", {28'd0, ptr}, 3);
        check("burst_nopulse", {31'd0, i2c_wr_valid}, 0);
        check("burst_inval", {31'd0, m_axis_tvalid}, 0);
        send(8'hAA, 1'b0);
        check("burst_pulse1", {31'd0, i2c_wr_valid}, 1);
        check("burst_addr1", {28'd0, i2c_wr_addr}, 3);
        check("burst_data1", {24'd0, i2c_wr_data}, 8'hAA);
        send(8'hBB, 1'b1);
        check("burst_pulse2", {31'd0, i2c_wr_valid}, 1);
        check("burst_addr2", {28'd0, i2c_wr_addr}, 4);
        check("burst_data2", {24'd0, i2c_wr_data}, 8'hBB);
        check("burst_ptr", {28'd0, ptr}, 5);
        tick();
        check("burst_pulse_end", {31'd0, i2c_wr_valid}, 0);
        check("burst_reload", {31'd0, m_axis_tvalid}, 1);
        bus_addressed = 1'b0;
        tick();
        tick();

        // Local write / readback table
        for (int i = 0; i < 6; i++) begin
            reg_wr_en   = 1'b1;
            reg_wr_addr = lv[i].wa;
            reg_wr_data = lv[i].wd;
            reg_rd_addr = lv[i].ra;
            tick();
            reg_wr_en = 1'b0;
            tick();
            check($sformatf("table_rd[%0d]", i), {24'd0, reg_rd_data}, {24'd0, lv[i].exp_rd});
        end
        local_read(4'h5, 8'h5A, "table_wr5");

        // Pointer wrap
        bus_addressed = 1'b1;
        send(8'h1F, 1'b0);
        check("wrap_ptr0", {28'd0, ptr}, 15);
        send(8'h11, 1'b0);
        check("wrap_addr1", {28'd0, i2c_wr_addr}, 15);
        send(8'h22, 1'b1);
        check("wrap_addr2", {28'd0, i2c_wr_addr}, 0);
        check("wrap_ptr", {28'd0, ptr}, 1);
        bus_addressed = 1'b0;
        tick();
        tick();
        local_read(4'hF, 8'h11, "wrap_reg15");
        local_read(4'h0, 8'h22, "wrap_reg0");

        // Read with auto-increment
        bus_addressed = 1'b1;
        send(8'h04, 1'b1);
        check("rd_ptr", {28'd0, ptr}, 4);
        check("rd_inval", {31'd0, m_axis_tvalid}, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rd_valid[%0d]", k), {31'd0, m_axis_tvalid}, 1);
            check($sformatf("rd_data[%0d]", k), {24'd0, m_axis_tdata}, {24'd0, rd_exp[k]});
            m_axis_tready = 1'b1;
            tick();
            m_axis_tready = 1'b0;
            check($sformatf("rd_gap[%0d]", k), {31'd0, m_axis_tvalid}, 0);
            tick();
        end
        bus_addressed = 1'b0;
        tick();
        tick();
        check("rd_ptr_end", {28'd0, ptr}, 7);

        // Read-only register
        bus_addressed = 1'b1;
        send(8'h02, 1'b0);
        send(8'h55, 1'b1);
        check("ro_nopulse", {31'd0, i2c_wr_valid}, 0);
        check("ro_ptr", {28'd0, ptr}, 3);
        bus_addressed = 1'b0;
        tick();
        local_read(4'h2, 8'h00, "ro_unchanged");
        reg_wr_en   = 1'b1;
        reg_wr_addr = 4'h2;
        reg_wr_data = 8'h66;
        tick();
        reg_wr_en = 1'b0;
        check("ro_local_old", {24'd0, reg_rd_data}, 0);
        tick();
        check("ro_local_new", {24'd0, reg_rd_data}, 8'h66);

        // Collision and invalidation
        bus_addressed = 1'b1;
        send(8'h08, 1'b0);
        tick();
        s_axis_tdata  = 8'h77;
        s_axis_tvalid = 1'b1;
        reg_wr_en     = 1'b1;
        reg_wr_addr   = 4'h8;
        reg_wr_data   = 8'h88;
        reg_rd_addr   = 4'h8;
        tick();
        s_axis_tvalid = 1'b0;
        reg_wr_en     = 1'b0;
        check("col_inval", {31'd0, m_axis_tvalid}, 0);
        check("col_pulse_data", {24'd0, i2c_wr_data}, 8'h77);
        check("col_ptr", {28'd0, ptr}, 9);
        tick();
        check("col_reload", {31'd0, m_axis_tvalid}, 1);
        check("col_reg", {24'd0, reg_rd_data}, 8'h77);
        reg_wr_en   = 1'b1;
        reg_wr_addr = 4'h9;
        reg_wr_data = 8'h99;
        tick();
        reg_wr_en = 1'b0;
        check("lw_inval", {31'd0, m_axis_tvalid}, 0);
        tick();
        check("lw_reload_valid", {31'd0, m_axis_tvalid}, 1);
        check("lw_reload_data", {24'd0, m_axis_tdata}, 8'h99);
        bus_addressed = 1'b0;
        tick();
        tick();

        // Reset mid-write; first byte after the bus drop must be a pointer
        bus_addressed = 1'b1;
        send(8'h06, 1'b0);
        check("mid_ptr", {28'd0, ptr}, 6);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_ptr", {28'd0, ptr}, 0);
        check("mid_rst_tready", {31'd0, s_axis_tready}, 0);
        check("mid_rst_tvalid", {31'd0, m_axis_tvalid}, 0);
        check("mid_rst_tdata", {24'd0, m_axis_tdata}, 0);
        check("mid_rst_rd", {24'd0, reg_rd_data}, 0);
        check("mid_rst_wr", {28'd0, i2c_wr_addr}, 0);
        #1;
        rst = 1'b0;
        tick();
        check("mid_reload", {31'd0, m_axis_tvalid}, 1);
        send(8'h01, 1'b0);
        check("mid_newptr", {28'd0, ptr}, 1);
        check("mid_nowrite", {31'd0, i2c_wr_valid}, 0);
        send(8'h5C, 1'b1);
        check("mid_data_addr", {28'd0, i2c_wr_addr}, 1);
        bus_addressed = 1'b0;
        tick();
        local_read(4'h3, 8'h00, "mid_cleared");
        local_read(4'h1, 8'h5C, "mid_written");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
